store_mem_data: RTL
===================

Name: store_mem_data

Overview:
- M-stage store path: counterpart to the load-side data extractor.
- Takes store address, register data and Storeop; produces lane-aligned write data plus a 4-bit byte enable.
- Buffers stores in a small FIFO and drains them to the data-memory write port under a req/ack handshake, so a stalling DM does not stall M.
- Sits between the M-stage pipeline register and DM; store_pending feeds the hazard unit.

Parameters:
DEPTH, 2, store FIFO entries; power of 2, >= 2
ADDR_W, 32, address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low (0 = reset)
st_valid  input  1  M stage presents a store request
st_ready  output  1  buffer can accept this cycle
Storeop  input  4  0=none, 1=SW, 2=SH, 3=SB, others reserved
ALUresult_M  input  32  byte address of the store
RT_data_M  input  32  unaligned store data (low bits significant for SH/SB)
mem_we  output  1  write request to DM, head entry valid
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_byteen  output  4  byte-lane enables
mem_wdata  output  32  lane-aligned write data
mem_ack  input  1  DM accepted head write this cycle
store_pending  output  1  FIFO non-empty
align_err  output  1  misaligned store dropped (macro only; else tied 0)

Behaviour:
- Reset (reset==0 at clk edge):
  - count, rd_ptr and wr_ptr go to 0.
  - Outputs: mem_we=0, mem_addr=0, mem_byteen=0, mem_wdata=0, store_pending=0, align_err=0.
  - st_ready is combinational from count, so it reads 1 in the cycle after reset.
  - Reset mid-drain discards every entry; the in-flight write is abandoned and mem_ack is ignored during reset.
- st_ready = (count != DEPTH). It does not depend on a same-cycle pop.
- Push: st_valid & st_ready & Storeop in {1,2,3}.
  - Storeop 0 or reserved with st_valid=1: handshake completes, nothing enqueued.
- Lane formatting at push, with a = ALUresult_M[1:0]:
  - SW: byteen=1111, wdata=RT.
  - SH: a[1]=0 -> byteen=0011, wdata={16'h0,RT[15:0]}; a[1]=1 -> byteen=1100, wdata={RT[15:0],16'h0}.
  - SB: byteen=0001<<a, wdata=RT[7:0]<<(8*a).
  - Unused lanes are always 0.
- Pop: mem_we & mem_ack.
- mem_we/mem_addr/mem_byteen/mem_wdata are driven from the head entry, combinationally from the registered FIFO state.
  - Latency: store accepted at edge N -> mem_we=1 in cycle N+1 when the FIFO was empty.
  - Head fields hold stable while mem_ack=0.
- Simultaneous push and pop: both happen and count is unchanged. This is legal only when not full, since st_ready blocks a push at DEPTH.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- store_pending = (count != 0). mem_we equals store_pending.
- mem_ack while mem_we=0 is ignored.

Optional Feature:
STORE_ALIGN_CHECK_EN
- Defined:
  - SW with a!=0, or SH with a[0]=1, completes the handshake but is not enqueued.
  - align_err is a registered 1-cycle pulse in the cycle after the handshake.
- Undefined:
  - SW ignores a; SH ignores a[0]; all such stores are enqueued.
  - align_err is constant 0.

Decomposition:
- Shared package (mips_defs) holds:
  - Storeop codes ST_NONE/ST_SW/ST_SH/ST_SB, alongside the existing Loadop codes.
  - BYTEEN_* constants.
- Sub-module store_lane_fmt: the combinational Storeop+addr -> {byteen, wdata} formatter, with no state.
- The FIFO and handshake logic live in store_mem_data.

Test Plan:
1. Reset, then push SW addr=0x100 data=0xDEADBEEF with mem_ack=1. Next cycle: mem_we=1, mem_addr=0x100, byteen=1111, wdata=0xDEADBEEF. Cycle after that: mem_we=0.
2. SB addr=0x203 data=0x000000A5, then SH addr=0x202 data=0x1234. With mem_ack=1 they appear in order: first byteen=1000 wdata=0xA5000000, then byteen=1100 wdata=0x12340000.
3. Hold mem_ack=0 and push 3 stores (DEPTH=2). st_ready drops after 2 pushes, and the 3rd waits. Head stays stable. Raise mem_ack and all three drain in order.
4. With count=1 and mem_ack=1, push on the same cycle. count stays 1 and the next head is the new store.
5. Pull reset low while 2 entries are pending. Next cycle: mem_we=0 and store_pending=0. Later acks write nothing.
6. Macro defined: SW addr=0x102 -> align_err=1 for exactly one cycle, nothing written. Macro undefined: the same store writes mem_addr=0x100 with byteen=1111.

Source files
------------

// File: rtl/mips_defs.sv
// -----------------------------------------------------------------------------
// mips_defs : shared pipeline definitions
//
// Purpose : Load/store operation codes and byte-enable constants shared by
//           the M-stage load extractor and store path.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mips_defs;

   // Loadop codes (load-side data extractor)
   localparam logic [3:0] LD_NONE = 4'd0;
   localparam logic [3:0] LD_LW   = 4'd1;
   localparam logic [3:0] LD_LH   = 4'd2;
   localparam logic [3:0] LD_LHU  = 4'd3;
   localparam logic [3:0] LD_LB   = 4'd4;
   localparam logic [3:0] LD_LBU  = 4'd5;

   // Storeop codes; 4..15 are reserved and behave like ST_NONE
   localparam logic [3:0] ST_NONE = 4'd0;
   localparam logic [3:0] ST_SW   = 4'd1;
   localparam logic [3:0] ST_SH   = 4'd2;
   localparam logic [3:0] ST_SB   = 4'd3;

   // Byte-lane enables, bit i enables data bits [8i+7:8i]
   localparam logic [3:0] BYTEEN_NONE    = 4'b0000;
   localparam logic [3:0] BYTEEN_WORD    = 4'b1111;
   localparam logic [3:0] BYTEEN_HALF_LO = 4'b0011;
   localparam logic [3:0] BYTEEN_HALF_HI = 4'b1100;
   localparam logic [3:0] BYTEEN_BYTE0   = 4'b0001;

   function automatic logic is_store(input logic [3:0] op);
      return (op == ST_SW) || (op == ST_SH) || (op == ST_SB);
   endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// -----------------------------------------------------------------------------
// store_lane_fmt : combinational store lane formatter
//
// Purpose : Turns Storeop + low address bits + register data into a
//           lane-aligned write word and byte enable. No state.
// Ports   : storeop   in  4   store operation code
//           addr_lo   in  2   byte offset within the word
//           data      in  32  unaligned register data
//           byteen    out 4   byte-lane enables (0 for non-stores)
//           wdata     out 32  lane-aligned data, unused lanes 0
//           enqueue   out 1   this op produces a memory write
//           bad_align out 1   valid store op rejected for misalignment
// Parameter CHECK_ALIGN: 1 rejects SW with offset!=0 and SH with odd offset.
// -----------------------------------------------------------------------------
module store_lane_fmt
   import mips_defs::*;
#(
   parameter bit CHECK_ALIGN = 1'b0
) (
   input  logic [3:0]  storeop,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [3:0]  byteen,
   output logic [31:0] wdata,
   output logic        enqueue,
   output logic        bad_align
);

   logic misaligned;

   always_comb begin
      byteen     = BYTEEN_NONE;
      wdata      = '0;
      misaligned = 1'b0;
      case (storeop)
         ST_SW: begin
            byteen     = BYTEEN_WORD;
            wdata      = data;
            misaligned = (addr_lo != 2'b00);
         end
         ST_SH: begin
            // addr_lo[0] is ignored for lane selection
            if (addr_lo[1]) begin
               byteen = BYTEEN_HALF_HI;
               wdata  = {data[15:0], 16'h0000};
            end else begin
               byteen = BYTEEN_HALF_LO;
               wdata  = {16'h0000, data[15:0]};
            end
            misaligned = addr_lo[0];
         end
         ST_SB: begin
            byteen = BYTEEN_BYTE0 << addr_lo;
            wdata  = {24'h000000, data[7:0]} << {addr_lo, 3'b000};
         end
         default: ;
      endcase
   end

   assign bad_align = is_store(storeop) & CHECK_ALIGN & misaligned;
   assign enqueue   = is_store(storeop) & ~bad_align;

endmodule

// File: rtl/store_mem_data.sv
// -----------------------------------------------------------------------------
// store_mem_data : M-stage store path with store buffer
//
// Purpose : Formats stores into lane-aligned write data, buffers them in a
//           DEPTH-entry FIFO and drains the head to data memory under a
//           mem_we/mem_ack handshake so a stalling DM does not stall M.
// Ports   : clk, reset (sync, active-low)
//           st_valid/st_ready     store handshake from M stage
//           Storeop, ALUresult_M, RT_data_M  store op, byte address, data
//           mem_we/mem_addr/mem_byteen/mem_wdata  head entry to DM
//           mem_ack               DM accepted head write
//           store_pending         FIFO non-empty (hazard unit)
//           align_err             1-cycle pulse, misaligned store dropped
// Macro   : STORE_ALIGN_CHECK_EN enables misaligned SW/SH rejection and
//           align_err; when undefined, align_err stays 0.
// -----------------------------------------------------------------------------
module store_mem_data
   import mips_defs::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [3:0]        Storeop,
   input  logic [ADDR_W-1:0] ALUresult_M,
   input  logic [31:0]       RT_data_M,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_byteen,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              store_pending,
   output logic              align_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef STORE_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              align_err_reg;

   logic [ADDR_W-1:0] addr_mem   [DEPTH];
   logic [3:0]        byteen_mem [DEPTH];
   logic [31:0]       wdata_mem  [DEPTH];

   logic [3:0]        fmt_byteen;
   logic [31:0]       fmt_wdata;
   logic              fmt_enqueue, fmt_bad_align;
   logic              handshake, push, pop;

   store_lane_fmt #(
      .CHECK_ALIGN (ALIGN_CHECK)
   ) u_fmt (
      .storeop   (Storeop),
      .addr_lo   (ALUresult_M[1:0]),
      .data      (RT_data_M),
      .byteen    (fmt_byteen),
      .wdata     (fmt_wdata),
      .enqueue   (fmt_enqueue),
      .bad_align (fmt_bad_align)
   );

   assign st_ready      = (count_reg != CNT_W'(DEPTH));
   assign store_pending = (count_reg != '0);
   assign mem_we        = store_pending;

   // Non-store ops and rejected stores still complete the handshake.
   assign handshake = st_valid & st_ready;
   assign push      = handshake & fmt_enqueue;
   assign pop       = mem_we & mem_ack;

   // Head fields are forced to 0 while empty so stale entries never leak.
   assign mem_addr   = mem_we ? addr_mem[rd_ptr_reg]   : '0;
   assign mem_byteen = mem_we ? byteen_mem[rd_ptr_reg] : '0;
   assign mem_wdata  = mem_we ? wdata_mem[rd_ptr_reg]  : '0;

   // Entry storage: payload only, validity is tracked by count/pointers.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
               addr_mem[gi]   <= {ALUresult_M[ADDR_W-1:2], 2'b00};
               byteen_mem[gi] <= fmt_byteen;
               wdata_mem[gi]  <= fmt_wdata;
            end
         end
      end
   endgenerate

   // Control state; reset takes priority over any in-flight ack.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_reg    <= '0;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         align_err_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         // fmt_bad_align is constant 0 when the check is disabled
         align_err_reg <= handshake & fmt_bad_align;
      end
   end

   assign align_err = align_err_reg;

endmodule
